pipe_stage_chain: RTL and testbench
===================================

// Module: pipe_stage_chain
// PURPOSE
//  Parametrised chain of NSTAGE pipeline registers, each carrying a valid bit, a control
//  field and a data field. Successor to the fixed IF/ID/EX/MEM/WB latches: adds per-stage
//  stall (hold), flush (bubble), automatic bubble insertion behind a stall, and saturating
//  stall/bubble counters. Sits between the pipeline stages; hazard unit drives STALL/FLUSH.
// PARAMETERS
//  NSTAGE  4   number of register slots (>=1); slot 0 captures IN_*, slot k captures slot k-1
//  CW      16  control field width (RegWrite, MemWrite, MemtoReg, ... packed); zeroed on bubble
//  DW      96  data field width (PC, PC+4, operands, imm, rd ... packed); never forced on bubble
//  CNTW    32  width of each performance counter
// PORTS
//  CLK         in   1            clock, all state updates on posedge
//  RST_N       in   1            synchronous active-low reset, sampled on posedge CLK
//  IN_VALID    in   1            slot-0 input carries a real instruction
//  IN_CTRL     in   CW           slot-0 control input
//  IN_DATA     in   DW           slot-0 data input
//  IN_READY    out  1            slot 0 will accept IN_* this cycle (= ~HOLD[0])
//  STALL       in   NSTAGE       STALL[k]=1: slot k must keep its contents this cycle
//  FLUSH       in   NSTAGE       FLUSH[k]=1: slot k becomes a bubble at next edge
//  OUT_VALID   out  NSTAGE       valid bit of every slot
//  OUT_CTRL    out  NSTAGE*CW    control of slot k at bits [k*CW +: CW]
//  OUT_DATA    out  NSTAGE*DW    data of slot k at bits [k*DW +: DW]
//  HOLD        out  NSTAGE       effective hold per slot (see below)
//  STALL_CNT   out  CNTW         cycles with HOLD[0]=1
//  BUBBLE_CNT  out  CNTW         cycles with OUT_VALID[NSTAGE-1]=0 after reset
// BEHAVIOUR
//  - Reset (RST_N=0 at edge): all VALID=0, CTRL=0, DATA=0, both counters=0; STALL/FLUSH ignored.
//  - HOLD[k] = |STALL[NSTAGE-1:k] (combinational): a stall holds its slot and every upstream slot.
//  - Per-slot next state, priority order:
//    1 FLUSH[k]              -> VALID<=0, CTRL<=0, DATA unchanged (flush beats hold)
//    2 HOLD[k]               -> all fields unchanged
//    3 k>0 and HOLD[k-1]     -> bubble: VALID<=0, CTRL<=0, DATA unchanged
//    4 otherwise             -> VALID<=src_valid, CTRL<=src_valid?src_ctrl:0, DATA<=src_data
//    src = IN_* for k=0, slot k-1 for k>0. Invariant: VALID=0 implies CTRL=0.
//  - Latency: IN_* appears on slot NSTAGE-1 after exactly NSTAGE edges with no STALL/FLUSH.
//  - IN_READY=0 means IN_* not consumed; producer must re-present it. FLUSH[0] with HOLD[0]
//    empties slot 0 but IN_READY stays 0 that cycle (instruction not taken).
//  - FLUSH on a slot whose successor is held: successor unaffected; flushed slot stays bubble.
//  - Counters increment by 1 per qualifying cycle, saturate at all-ones, never wrap.
//  - BUBBLE_CNT counts from the first edge after reset release; reset mid-run clears everything
//    in one edge regardless of in-flight STALL/FLUSH.
//  - X on STALL/FLUSH while RST_N=0 must not propagate to state.
// STRUCTURE
//  - Shared include pipe_defs.vh: CTRL bit-position `defines (CTRL_REGWRITE, CTRL_MEMWRITE,
//    CTRL_MEMTOREG_LSB...), default CW/DW, NOP control constant (all zero).
//  - One sub-module pipe_reg_slot (CW, DW): one slot with flush/hold/bubble/load priority;
//    top generates NSTAGE instances, computes HOLD prefix-OR, IN_READY and the two counters.
// TESTING
//  - Reset: drive X-free random inputs with RST_N=0 3 cycles -> all outputs 0, IN_READY=1.
//  - Streaming NSTAGE=4: IN_DATA=1,2,3,... valid each cycle -> OUT_DATA slot3 =1 at edge 4, then
//    +1 per cycle; BUBBLE_CNT=3 after edge 4 and constant afterwards.
//  - Stall STALL[1]=1 for 2 cycles mid-stream -> slots 0,1 frozen, IN_READY=0, slot 2 receives
//    2 bubbles (VALID=0, CTRL=0), STALL_CNT=2, no data lost or duplicated at slot 3.
//  - Flush FLUSH[1:0]=2'b11 one cycle (branch taken) -> slots 0,1 VALID=0 CTRL=0 next edge,
//    slots 2,3 advance normally; FLUSH[1] with STALL[1] same cycle -> slot 1 bubble.
//  - Saturation CNTW=4: hold STALL[0]=1 20 cycles -> STALL_CNT stops at 15.
//  - Reset mid-operation with STALL=all-ones, FLUSH=0 -> next edge all state 0; stream restarts clean.

Source files
------------

// File: rtl/pipe_stage_chain_pkg.sv
// Shared definitions for the pipeline register chain: default sizes, control-field
// bit positions and the per-slot update decision.
package pipe_stage_chain_pkg;

   localparam int DEF_NSTAGE = 4;
   localparam int DEF_CW     = 16;
   localparam int DEF_DW     = 96;
   localparam int DEF_CNTW   = 32;

   // Bit positions inside the packed control field; a bubble carries all-zero control.
   localparam int CTRL_REGWRITE     = 0;
   localparam int CTRL_MEMWRITE     = 1;
   localparam int CTRL_MEMTOREG_LSB = 2;
   localparam int CTRL_BRANCH       = 4;
   localparam int CTRL_ALUSRC       = 5;
   localparam int CTRL_ALUOP_LSB    = 6;

   typedef enum logic [1:0] {
      SLOT_LOAD,
      SLOT_BUBBLE,
      SLOT_HOLD,
      SLOT_FLUSH
   } slot_action_e;

   // Flush wins over hold; a slot whose upstream neighbour is held takes a bubble.
   function automatic slot_action_e slot_action(input logic flush,
                                                input logic hold,
                                                input logic upstream_hold);
      if (flush)              return SLOT_FLUSH;
      else if (hold)          return SLOT_HOLD;
      else if (upstream_hold) return SLOT_BUBBLE;
      else                    return SLOT_LOAD;
   endfunction

endpackage

// File: rtl/pipe_stage_chain_reg_slot.sv
// One pipeline register slot holding valid, control and data, with
// flush / hold / bubble / load priority.
module pipe_stage_chain_reg_slot
   import pipe_stage_chain_pkg::*;
#(
   parameter int CW = DEF_CW,
   parameter int DW = DEF_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          hold,
   input  logic          upstream_hold,
   input  logic          src_valid,
   input  logic [CW-1:0] src_ctrl,
   input  logic [DW-1:0] src_data,
   output logic          valid,
   output logic [CW-1:0] ctrl,
   output logic [DW-1:0] data,
   output logic          next_valid
);

   slot_action_e action;

   always_comb begin
      action     = slot_action(flush, hold, upstream_hold);
      next_valid = valid;
      case (action)
         SLOT_FLUSH, SLOT_BUBBLE: next_valid = 1'b0;
         SLOT_HOLD:               next_valid = valid;
         default:                 next_valid = src_valid;
      endcase
   end

   // Data is never forced on a bubble; only valid and control are cleared.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid <= 1'b0;
         ctrl  <= '0;
         data  <= '0;
      end else begin
         case (action)
            SLOT_FLUSH, SLOT_BUBBLE: begin
               valid <= 1'b0;
               ctrl  <= '0;
            end
            SLOT_HOLD: begin
               valid <= valid;
            end
            default: begin
               valid <= src_valid;
               ctrl  <= src_valid ? src_ctrl : '0;
               data  <= src_data;
            end
         endcase
      end
   end

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised chain of pipeline register slots with stall propagation, flush,
// automatic bubble insertion and saturating stall/bubble counters.
module pipe_stage_chain
   import pipe_stage_chain_pkg::*;
#(
   parameter int NSTAGE = DEF_NSTAGE,
   parameter int CW     = DEF_CW,
   parameter int DW     = DEF_DW,
   parameter int CNTW   = DEF_CNTW
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 IN_VALID,
   input  logic [CW-1:0]        IN_CTRL,
   input  logic [DW-1:0]        IN_DATA,
   output logic                 IN_READY,
   input  logic [NSTAGE-1:0]    STALL,
   input  logic [NSTAGE-1:0]    FLUSH,
   output logic [NSTAGE-1:0]    OUT_VALID,
   output logic [NSTAGE*CW-1:0] OUT_CTRL,
   output logic [NSTAGE*DW-1:0] OUT_DATA,
   output logic [NSTAGE-1:0]    HOLD,
   output logic [CNTW-1:0]      STALL_CNT,
   output logic [CNTW-1:0]      BUBBLE_CNT
);

   localparam logic [CNTW-1:0] CNT_ONE = 1;

   logic [NSTAGE-1:0] hold_vec;
   logic [NSTAGE-1:0] next_valid;

   // A stall freezes its own slot and everything upstream of it.
   assign hold_vec[NSTAGE-1] = STALL[NSTAGE-1];
   for (genvar k = 0; k < NSTAGE - 1; k++) begin : g_hold
      assign hold_vec[k] = STALL[k] | hold_vec[k+1];
   end

   assign HOLD     = hold_vec;
   assign IN_READY = ~hold_vec[0];

   for (genvar k = 0; k < NSTAGE; k++) begin : g_slot
      if (k == 0) begin : g_first
         pipe_stage_chain_reg_slot #(.CW(CW), .DW(DW)) u_slot (
            .clk           (CLK),
            .rst_n         (RST_N),
            .flush         (FLUSH[0]),
            .hold          (hold_vec[0]),
            .upstream_hold (1'b0),
            .src_valid     (IN_VALID),
            .src_ctrl      (IN_CTRL),
            .src_data      (IN_DATA),
            .valid         (OUT_VALID[0]),
            .ctrl          (OUT_CTRL[0 +: CW]),
            .data          (OUT_DATA[0 +: DW]),
            .next_valid    (next_valid[0])
         );
      end else begin : g_rest
         pipe_stage_chain_reg_slot #(.CW(CW), .DW(DW)) u_slot (
            .clk           (CLK),
            .rst_n         (RST_N),
            .flush         (FLUSH[k]),
            .hold          (hold_vec[k]),
            .upstream_hold (hold_vec[k-1]),
            .src_valid     (OUT_VALID[k-1]),
            .src_ctrl      (OUT_CTRL[(k-1)*CW +: CW]),
            .src_data      (OUT_DATA[(k-1)*DW +: DW]),
            .valid         (OUT_VALID[k]),
            .ctrl          (OUT_CTRL[k*CW +: CW]),
            .data          (OUT_DATA[k*DW +: DW]),
            .next_valid    (next_valid[k])
         );
      end
   end

   // Bubble counting looks at the value the last slot takes at this edge, so the
   // first post-reset edge already counts an empty output cycle.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         STALL_CNT  <= '0;
         BUBBLE_CNT <= '0;
      end else begin
         if (hold_vec[0] && (STALL_CNT != '1))
            STALL_CNT <= STALL_CNT + CNT_ONE;
         if (!next_valid[NSTAGE-1] && (BUBBLE_CNT != '1))
            BUBBLE_CNT <= BUBBLE_CNT + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed self-checking bench for pipe_stage_chain: reset, streaming, stall,
// flush, flush-with-stall, mid-run reset and counter saturation.
module tb_pipe_stage_chain;
   import pipe_stage_chain_pkg::*;

   localparam int NS = 4;
   localparam int CW = 16;
   localparam int DW = 32;
   localparam logic [CW-1:0] CTRL_BASE = (16'd1 << CTRL_REGWRITE) | (16'd1 << CTRL_MEMTOREG_LSB);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic [CW-1:0]    in_ctrl;
   logic [DW-1:0]    in_data;
   logic [NS-1:0]    stall;
   logic [NS-1:0]    flush;

   logic             in_ready;
   logic [NS-1:0]    out_valid;
   logic [NS*CW-1:0] out_ctrl;
   logic [NS*DW-1:0] out_data;
   logic [NS-1:0]    hold;
   logic [31:0]      stall_cnt;
   logic [31:0]      bubble_cnt;

   logic             sat_in_ready;
   logic [NS-1:0]    sat_out_valid;
   logic [NS*CW-1:0] sat_out_ctrl;
   logic [NS*DW-1:0] sat_out_data;
   logic [NS-1:0]    sat_hold;
   logic [3:0]       sat_stall_cnt;
   logic [3:0]       sat_bubble_cnt;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   pipe_stage_chain #(.NSTAGE(NS), .CW(CW), .DW(DW), .CNTW(32)) dut (
      .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_CTRL(in_ctrl), .IN_DATA(in_data),
      .IN_READY(in_ready), .STALL(stall), .FLUSH(flush), .OUT_VALID(out_valid),
      .OUT_CTRL(out_ctrl), .OUT_DATA(out_data), .HOLD(hold),
      .STALL_CNT(stall_cnt), .BUBBLE_CNT(bubble_cnt)
   );

   pipe_stage_chain #(.NSTAGE(NS), .CW(CW), .DW(DW), .CNTW(4)) dut_sat (
      .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_CTRL(in_ctrl), .IN_DATA(in_data),
      .IN_READY(sat_in_ready), .STALL(stall), .FLUSH(flush), .OUT_VALID(sat_out_valid),
      .OUT_CTRL(sat_out_ctrl), .OUT_DATA(sat_out_data), .HOLD(sat_hold),
      .STALL_CNT(sat_stall_cnt), .BUBBLE_CNT(sat_bubble_cnt)
   );

   function automatic logic [CW-1:0] ctrl_for(input logic [DW-1:0] d);
      return CTRL_BASE | {d[7:0], 8'h00};
   endfunction

   function automatic logic [DW-1:0] data_of(input int k);
      return out_data[k*DW +: DW];
   endfunction

   function automatic logic [CW-1:0] ctrl_of(input int k);
      return out_ctrl[k*CW +: CW];
   endfunction

   task automatic apply_stimulus(input logic v, input logic [DW-1:0] d,
                                 input logic [NS-1:0] st, input logic [NS-1:0] fl);
      in_valid = v;
      in_data  = d;
      in_ctrl  = ctrl_for(d);
      stall    = st;
      flush    = fl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      // Reset with random, X-free inputs
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'($urandom), $urandom, 4'($urandom), 4'($urandom));
         tick();
      end
      check_output("reset_valid", 64'(out_valid), 64'h0);
      check_output("reset_ctrl", 64'(out_ctrl), 64'h0);
      check_output("reset_data_lo", out_data[63:0], 64'h0);
      check_output("reset_data_hi", out_data[127:64], 64'h0);
      check_output("reset_stall_cnt", 64'(stall_cnt), 64'h0);
      check_output("reset_bubble_cnt", 64'(bubble_cnt), 64'h0);

      // Streaming 1,2,3,... : slot 3 shows 1 after edge 4
      apply_stimulus(1'b1, 32'd1, 4'b0000, 4'b0000);
      rst_n = 1'b1;
      #1;
      check_output("reset_in_ready", 64'(in_ready), 64'h1);
      check_output("reset_hold", 64'(hold), 64'h0);
      for (int e = 1; e <= 6; e++) begin
         apply_stimulus(1'b1, 32'(e), 4'b0000, 4'b0000);
         tick();
         if (e == 3) check_output("stream_slot3_empty", 64'(out_valid), 64'h7);
         if (e >= 4) begin
            check_output("stream_slot3_data", 64'(data_of(3)), 64'(e - 3));
            check_output("stream_bubble_cnt", 64'(bubble_cnt), 64'd3);
         end
      end
      check_output("stream_slot3_ctrl", 64'(ctrl_of(3)), 64'(ctrl_for(32'd3)));
      check_output("stream_valid_all", 64'(out_valid), 64'hF);

      // STALL[1] for two cycles: slots 0,1 frozen, slot 2 takes bubbles
      apply_stimulus(1'b1, 32'd7, 4'b0010, 4'b0000);
      check_output("stall_hold", 64'(hold), 64'h3);
      check_output("stall_in_ready", 64'(in_ready), 64'h0);
      tick();
      check_output("stall1_slot2_valid", 64'(out_valid[2]), 64'h0);
      check_output("stall1_slot2_ctrl", 64'(ctrl_of(2)), 64'h0);
      check_output("stall1_slot3_data", 64'(data_of(3)), 64'd4);
      check_output("stall1_stall_cnt", 64'(stall_cnt), 64'd1);
      tick();
      check_output("stall2_valid", 64'(out_valid), 64'h3);
      check_output("stall2_slot0_data", 64'(data_of(0)), 64'd6);
      check_output("stall2_slot1_data", 64'(data_of(1)), 64'd5);
      check_output("stall2_stall_cnt", 64'(stall_cnt), 64'd2);
      apply_stimulus(1'b1, 32'd7, 4'b0000, 4'b0000);
      tick();
      check_output("post_stall_slot3_bubble", 64'(out_valid[3]), 64'h0);
      apply_stimulus(1'b1, 32'd8, 4'b0000, 4'b0000);
      tick();
      check_output("post_stall_slot3_data", 64'(data_of(3)), 64'd5);
      check_output("post_stall_valid", 64'(out_valid), 64'hF);
      check_output("post_stall_stall_cnt", 64'(stall_cnt), 64'd2);
      check_output("post_stall_bubble_cnt", 64'(bubble_cnt), 64'd5);

      // Branch-taken flush of slots 0 and 1
      apply_stimulus(1'b1, 32'd9, 4'b0000, 4'b0011);
      tick();
      check_output("flush_valid", 64'(out_valid), 64'hC);
      check_output("flush_ctrl01", 64'(out_ctrl[31:0]), 64'h0);
      check_output("flush_slot0_data_kept", 64'(data_of(0)), 64'd8);
      check_output("flush_slot2_data", 64'(data_of(2)), 64'd7);
      check_output("flush_slot3_data", 64'(data_of(3)), 64'd6);
      for (int e = 10; e <= 13; e++) begin
         apply_stimulus(1'b1, 32'(e), 4'b0000, 4'b0000);
         tick();
         if (e == 11) check_output("flush_slot3_ctrl_bubble", 64'(ctrl_of(3)), 64'h0);
      end
      check_output("flush_slot3_resume", 64'(data_of(3)), 64'd10);
      check_output("flush_bubble_cnt", 64'(bubble_cnt), 64'd7);

      // FLUSH[1] together with STALL[1]: flush wins on slot 1
      apply_stimulus(1'b1, 32'd14, 4'b0010, 4'b0010);
      tick();
      check_output("flush_stall_valid", 64'(out_valid), 64'h9);
      check_output("flush_stall_slot1_ctrl", 64'(ctrl_of(1)), 64'h0);
      check_output("flush_stall_slot1_data", 64'(data_of(1)), 64'd12);
      check_output("flush_stall_slot3_data", 64'(data_of(3)), 64'd11);
      check_output("flush_stall_stall_cnt", 64'(stall_cnt), 64'd3);
      apply_stimulus(1'b1, 32'd14, 4'b0000, 4'b0000);
      tick();
      check_output("flush_stall_after_valid", 64'(out_valid), 64'h3);
      check_output("flush_stall_after_bubble", 64'(bubble_cnt), 64'd8);

      // Reset mid-run with every slot stalled
      rst_n = 1'b0;
      apply_stimulus(1'b1, 32'd15, 4'b1111, 4'b0000);
      tick();
      check_output("midreset_valid", 64'(out_valid), 64'h0);
      check_output("midreset_data_lo", out_data[63:0], 64'h0);
      check_output("midreset_ctrl", 64'(out_ctrl), 64'h0);
      check_output("midreset_stall_cnt", 64'(stall_cnt), 64'h0);
      check_output("midreset_bubble_cnt", 64'(bubble_cnt), 64'h0);
      rst_n = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         apply_stimulus(1'b1, 32'(e), 4'b0000, 4'b0000);
         tick();
      end
      check_output("restart_slot3_data", 64'(data_of(3)), 64'd1);
      check_output("restart_bubble_cnt", 64'(bubble_cnt), 64'd3);

      // Saturation: 20 cycles of STALL[0]
      apply_stimulus(1'b1, 32'd5, 4'b0001, 4'b0000);
      for (int i = 0; i < 20; i++) tick();
      check_output("sat_stall_cnt_wide", 64'(stall_cnt), 64'd20);
      check_output("sat_stall_cnt_narrow", 64'(sat_stall_cnt), 64'd15);
      check_output("sat_bubble_cnt_wide", 64'(bubble_cnt), 64'd21);
      check_output("sat_bubble_cnt_narrow", 64'(sat_bubble_cnt), 64'd15);
      check_output("sat_slot0_held", 64'(data_of(0)), 64'd4);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
